// File: rtl/panda_pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage Panda pipeline: hazard and redirect
// steering, memory-wait handling with timeout, halt/drain FSM, stall counter.
module panda_pipeline_ctrl #(
  parameter int unsigned DrainCycles = 4,
  parameter int unsigned MemTimeout  = 256,
  parameter int unsigned CntWidth    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_use_hazard_i,
  input  logic                branch_taken_i,
  input  logic                lsu_req_i,
  input  logic                lsu_rvalid_i,
  input  logic                halt_req_i,
  input  logic                resume_i,
  output logic                pc_stall_o,
  output logic                if_id_stall_o,
  output logic                if_id_flush_o,
  output logic                bubble_o,
  output logic                ex_mem_stall_o,
  output logic                halted_o,
  output logic                mem_timeout_o,
  output logic [CntWidth-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTING, HALTED} state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic [3:0]  drain_cnt;
  logic        mem_miss;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        bubble;
  logic        ex_mem_stall;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + {{(CntWidth-1){1'b0}}, 1'b1};
  endfunction

  assign mem_miss = lsu_req_i & ~lsu_rvalid_i;

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    bubble       = 1'b0;
    ex_mem_stall = 1'b0;
    unique case (state)
      RUN, MEM_WAIT: begin
        // In MEM_WAIT the whole pipe freezes until rvalid; that cycle then
        // resolves like a normal RUN cycle.
        if ((state == RUN && mem_miss) || (state == MEM_WAIT && !lsu_rvalid_i)) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end else if (branch_taken_i) begin
          if_id_flush = 1'b1;
          bubble      = 1'b1;
        end else if (load_use_hazard_i) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          bubble      = 1'b1;
        end
      end
      HALTING: begin
        if (mem_miss) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end else begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          bubble      = 1'b1;
        end
      end
      HALTED: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        bubble      = 1'b1;
      end
      default: ;
    endcase
  end

  // All steering outputs are forced low while reset is held.
  assign pc_stall_o     = pc_stall & ~rst_i;
  assign if_id_stall_o  = if_id_stall & ~rst_i;
  assign if_id_flush_o  = if_id_flush & ~rst_i;
  assign bubble_o       = bubble & ~rst_i;
  assign ex_mem_stall_o = ex_mem_stall & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      wait_cnt      <= '0;
      drain_cnt     <= '0;
      halted_o      <= 1'b0;
      mem_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      if (pc_stall) stall_cnt_o <= sat_inc(stall_cnt_o);
      unique case (state)
        RUN: begin
          if (mem_miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end else if (halt_req_i) begin
            state     <= HALTING;
            drain_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (lsu_rvalid_i) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt == 16'(MemTimeout - 1)) begin
              mem_timeout_o <= 1'b1;
              state         <= RUN;
            end
          end
        end
        HALTING: begin
          if (mem_miss) begin
            state <= HALTING;
          end else if (!halt_req_i) begin
            state <= RUN;
          end else if (drain_cnt == 4'(DrainCycles - 1)) begin
            state    <= HALTED;
            halted_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        HALTED: begin
          if (resume_i) begin
            state    <= RUN;
            halted_o <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_panda_pipeline_ctrl.sv
// Directed bench for panda_pipeline_ctrl (DrainCycles=4, MemTimeout=4, CntWidth=4).
module tb_panda_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_use_hazard, branch_taken, lsu_req, lsu_rvalid, halt_req, resume;
  logic       pc_stall, if_id_stall, if_id_flush, bubble, ex_mem_stall;
  logic       halted, mem_timeout;
  logic [3:0] stall_cnt;
  logic [4:0] ctl;
  int         total = 0;
  int         bad   = 0;

  // ctl order: {pc_stall, if_id_stall, if_id_flush, bubble, ex_mem_stall}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_MEM  = 5'b11001;
  localparam logic [4:0] C_DRN  = 5'b10110;
  localparam logic [4:0] C_HLT  = 5'b11010;

  assign ctl = {pc_stall, if_id_stall, if_id_flush, bubble, ex_mem_stall};

  always #5 clk = ~clk;

  panda_pipeline_ctrl #(
    .DrainCycles(4),
    .MemTimeout (4),
    .CntWidth   (4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .load_use_hazard_i(load_use_hazard),
    .branch_taken_i   (branch_taken),
    .lsu_req_i        (lsu_req),
    .lsu_rvalid_i     (lsu_rvalid),
    .halt_req_i       (halt_req),
    .resume_i         (resume),
    .pc_stall_o       (pc_stall),
    .if_id_stall_o    (if_id_stall),
    .if_id_flush_o    (if_id_flush),
    .bubble_o         (bubble),
    .ex_mem_stall_o   (ex_mem_stall),
    .halted_o         (halted),
    .mem_timeout_o    (mem_timeout),
    .stall_cnt_o      (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lu, input logic br, input logic req,
                       input logic rv, input logic hr, input logic rs);
    load_use_hazard = lu;
    branch_taken    = br;
    lsu_req         = req;
    lsu_rvalid      = rv;
    halt_req        = hr;
    resume          = rs;
  endtask

  // Apply one cycle of inputs and check the steering outputs mid-cycle.
  task automatic cyc(input string tag, input logic lu, input logic br, input logic req,
                     input logic rv, input logic hr, input logic rs, input logic [4:0] exp);
    drive(lu, br, req, rv, hr, rs);
    @(negedge clk);
    check(tag, 32'(ctl), 32'(exp));
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 1, 0, 1, 0);
    #3;
    check("rst_ctl", 32'(ctl), 32'(C_NONE));
    check("rst_halted", 32'(halted), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    @(posedge clk);
    nxt();
    rst = 1'b0;

    // load-use: one bubble
    cyc("lu", 1, 0, 0, 0, 0, 0, C_LU); nxt();
    cyc("lu_end", 0, 0, 0, 0, 0, 0, C_NONE);
    check("lu_cnt", 32'(stall_cnt), 1); nxt();

    // branch masks hazard
    cyc("br_mask", 1, 1, 0, 0, 0, 0, C_BR); nxt();
    cyc("br_end", 0, 0, 0, 0, 0, 0, C_NONE);
    check("br_cnt", 32'(stall_cnt), 1); nxt();

    // single-cycle memory
    cyc("mem_1cyc", 0, 0, 1, 1, 0, 0, C_NONE); nxt();

    // memory wait, rvalid three cycles after the request
    cyc("mw_req", 0, 0, 1, 0, 0, 0, C_MEM); nxt();
    cyc("mw_w1", 0, 1, 0, 0, 0, 0, C_MEM); nxt();
    cyc("mw_w2", 0, 1, 0, 0, 0, 0, C_MEM); nxt();
    cyc("mw_rvalid", 0, 1, 0, 1, 0, 0, C_BR); nxt();
    cyc("mw_run", 0, 0, 0, 0, 0, 0, C_NONE);
    check("mw_cnt", 32'(stall_cnt), 4); nxt();

    // timeout
    cyc("to_req", 0, 0, 1, 0, 0, 0, C_MEM);
    check("to_pre0", 32'(mem_timeout), 0); nxt();
    cyc("to_w1", 0, 0, 0, 0, 0, 0, C_MEM); nxt();
    cyc("to_w2", 0, 0, 0, 0, 0, 0, C_MEM); nxt();
    cyc("to_w3", 0, 0, 0, 0, 0, 0, C_MEM);
    check("to_pre3", 32'(mem_timeout), 0); nxt();
    cyc("to_run", 0, 0, 0, 0, 0, 0, C_NONE);
    check("to_set", 32'(mem_timeout), 1);
    check("to_cnt", 32'(stall_cnt), 8); nxt();
    cyc("to_run2", 0, 0, 0, 0, 0, 0, C_NONE);
    check("to_sticky", 32'(mem_timeout), 1); nxt();

    rst = 1'b1;
    #1;
    check("rst2_timeout", 32'(mem_timeout), 0);
    check("rst2_cnt", 32'(stall_cnt), 0);
    nxt();
    rst = 1'b0;

    // halt, drain four cycles, saturate counter in HALTED, resume
    cyc("h_run", 0, 0, 0, 0, 1, 0, C_NONE); nxt();
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("h_drain%0d", i), 0, 0, 0, 0, 1, 0, C_DRN);
      check($sformatf("h_drain%0d_halted", i), 32'(halted), 0);
      nxt();
    end
    cyc("h_halted", 0, 0, 0, 0, 1, 0, C_HLT);
    check("h_halted_o", 32'(halted), 1);
    check("h_cnt4", 32'(stall_cnt), 4); nxt();
    for (int i = 0; i < 20; i++) begin
      cyc("h_hold", 0, 0, 0, 0, 0, 0, C_HLT); nxt();
    end
    cyc("h_resume", 0, 0, 0, 0, 0, 1, C_HLT);
    check("h_sat", 32'(stall_cnt), 15); nxt();
    cyc("h_after", 0, 0, 0, 0, 0, 0, C_NONE);
    check("h_after_halted", 32'(halted), 0);
    check("h_nowrap", 32'(stall_cnt), 15); nxt();

    // halt request dropped during drain
    cyc("ab_run", 0, 0, 0, 0, 1, 0, C_NONE); nxt();
    cyc("ab_drn0", 0, 0, 0, 0, 1, 0, C_DRN); nxt();
    cyc("ab_drop", 0, 0, 0, 0, 0, 0, C_DRN); nxt();
    cyc("ab_back", 0, 0, 0, 0, 0, 0, C_NONE);
    check("ab_halted", 32'(halted), 0); nxt();

    // memory miss during drain holds the drain count
    cyc("hm_run", 0, 0, 0, 0, 1, 0, C_NONE); nxt();
    cyc("hm_miss", 0, 0, 1, 0, 1, 0, C_MEM); nxt();
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("hm_drain%0d", i), 0, 0, 0, 0, 1, 0, C_DRN); nxt();
    end
    cyc("hm_halted", 0, 0, 0, 0, 1, 0, C_HLT);
    check("hm_halted_o", 32'(halted), 1); nxt();

    // resume honoured while halt request still held; re-enter drain
    cyc("rh_resume", 0, 0, 0, 0, 1, 1, C_HLT); nxt();
    cyc("rh_run", 0, 0, 0, 0, 1, 0, C_NONE);
    check("rh_halted", 32'(halted), 0); nxt();
    cyc("rh_drain", 0, 0, 0, 0, 1, 0, C_DRN);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check("ar_ctl", 32'(ctl), 32'(C_NONE));
    check("ar_halted", 32'(halted), 0);
    check("ar_cnt", 32'(stall_cnt), 0);
    check("ar_timeout", 32'(mem_timeout), 0);
    nxt();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("ar_run", 0, 0, 0, 0, 0, 0, C_NONE);
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
